// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// datapath mux/ALU codes and the decoded opcode class.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_INIT      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_RD    = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WR    = 4'd6,
    ST_R_EXEC    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_ADDI_EXEC = 4'd10,
    ST_ADDI_WB   = 4'd11,
    ST_JUMP      = 4'd12
  } state_t;

  typedef enum logic [2:0] {
    CLS_LOAD    = 3'd0,
    CLS_STORE   = 3'd1,
    CLS_RTYPE   = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_ADDI    = 3'd4,
    CLS_JUMP    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } op_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] LS_WORD   = 2'b00;
  localparam logic [1:0] LS_HALF_S = 2'b01;
  localparam logic [1:0] LS_HALF_U = 2'b10;

  function automatic logic [1:0] load_size_of(input logic [5:0] op);
    logic [1:0] ls;
    case (op)
      OP_LH:   ls = LS_HALF_S;
      OP_LHU:  ls = LS_HALF_U;
      default: ls = LS_WORD;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/mc_op_class.sv
// Maps the instruction opcode onto the instruction class that steers the
// DECODE transition.
module mc_op_class
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_t  op_class
);

  // opcode to class lookup
  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OP_LW, OP_LH, OP_LHU: op_class = CLS_LOAD;
      OP_SW:                op_class = CLS_STORE;
      OP_RTYPE:             op_class = CLS_RTYPE;
      OP_BEQ:               op_class = CLS_BRANCH;
      OP_ADDI:              op_class = CLS_ADDI;
      OP_J:                 op_class = CLS_JUMP;
      default:              op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath, with a memory ready
// handshake and a watchdog that aborts memory accesses that never complete.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [1:0] load_size,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WD_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [5:0]       op_q_r;
  logic [CNT_W-1:0] wd_r;
  logic             illegal_op_r;
  logic             mem_timeout_r;
  op_class_t        op_class_s;
  logic             wd_wait_s;
  logic             wd_expire_s;

  mc_op_class u_op_class (
    .opcode   (opcode),
    .op_class (op_class_s)
  );

  // watchdog runs only while a memory-facing state is stalled
  always_comb begin
    wd_wait_s = 1'b0;
    case (state_r)
      ST_FETCH, ST_MEM_RD, ST_MEM_WR: wd_wait_s = !mem_ready;
      default:                        wd_wait_s = 1'b0;
    endcase
  end

  assign wd_expire_s = wd_wait_s && (wd_r == WD_LAST);

  // state sequencing, opcode latch, watchdog and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_INIT;
      op_q_r        <= 6'd0;
      wd_r          <= {CNT_W{1'b0}};
      illegal_op_r  <= 1'b0;
      mem_timeout_r <= 1'b0;
    end else begin
      illegal_op_r  <= 1'b0;
      mem_timeout_r <= wd_expire_s;
      // any state change leaves the wait condition false, so this also clears on exit
      if (wd_wait_s && !wd_expire_s) begin
        wd_r <= wd_r + WD_ONE;
      end else begin
        wd_r <= {CNT_W{1'b0}};
      end
      case (state_r)
        ST_INIT:  state_r <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ready) begin
            state_r <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          op_q_r <= opcode;
          case (op_class_s)
            CLS_LOAD, CLS_STORE: state_r <= ST_MEM_ADDR;
            CLS_RTYPE:           state_r <= ST_R_EXEC;
            CLS_BRANCH:          state_r <= ST_BRANCH;
            CLS_ADDI:            state_r <= ST_ADDI_EXEC;
            CLS_JUMP:            state_r <= ST_JUMP;
            default: begin
              state_r      <= ST_FETCH;
              illegal_op_r <= 1'b1;
            end
          endcase
        end
        ST_MEM_ADDR: state_r <= (op_q_r == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
        ST_MEM_RD: begin
          if (mem_ready) begin
            state_r <= ST_MEM_WB;
          end else if (wd_expire_s) begin
            state_r <= ST_FETCH;
          end
        end
        ST_MEM_WR: begin
          if (mem_ready || wd_expire_s) begin
            state_r <= ST_FETCH;
          end
        end
        ST_R_EXEC:    state_r <= ST_R_WB;
        ST_ADDI_EXEC: state_r <= ST_ADDI_WB;
        ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_ADDI_WB, ST_JUMP: state_r <= ST_FETCH;
        default:      state_r <= ST_FETCH;
      endcase
    end
  end

  // per-state strobe decode; only FETCH looks at mem_ready
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    load_size     = LS_WORD;
    case (state_r)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: alu_src_b = SRCB_IMM_SL2;
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        load_size  = load_size_of(op_q_r);
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      ST_ADDI_WB: reg_write = 1'b1;
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      default: pc_write = 1'b0;
    endcase
  end

  assign illegal_op  = illegal_op_r;
  assign mem_timeout = mem_timeout_r;
  assign state       = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller (watchdog set to 4).
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source, load_size;
  logic       illegal_op, mem_timeout;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .load_size(load_size), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .state(state)
  );

  always #5 clk = ~clk;

  // field order: pcw,pcwc,iord,mrd,mwr,irw,rdst,m2r,rw,asa,asb[2],aop[2],pcs[2],ls[2],ill,to
  logic [19:0] obs;
  assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, load_size, illegal_op, mem_timeout};

  localparam logic [19:0] C_ZERO      = 20'h00000;
  localparam logic [19:0] C_FETCH_RDY = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,4'b0000, 2'b01,2'b00,2'b00,2'b00,2'b00};
  localparam logic [19:0] C_FETCH_WT  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,4'b0000, 2'b01,2'b00,2'b00,2'b00,2'b00};
  localparam logic [19:0] C_DECODE    = {10'b0, 2'b11,2'b00,2'b00,2'b00,2'b00};
  localparam logic [19:0] C_MEM_ADDR  = {9'b0,1'b1, 2'b10,2'b00,2'b00,2'b00,2'b00};
  localparam logic [19:0] C_MEM_RD    = {1'b0,1'b0,1'b1,1'b1,6'b0, 10'b0};
  localparam logic [19:0] C_MEM_WR    = {1'b0,1'b0,1'b1,1'b0,1'b1,5'b0, 10'b0};
  localparam logic [19:0] C_WB_W      = {6'b0,1'b0,1'b1,1'b1,1'b0, 2'b00,2'b00,2'b00,2'b00,2'b00};
  localparam logic [19:0] C_WB_H      = {6'b0,1'b0,1'b1,1'b1,1'b0, 2'b00,2'b00,2'b00,2'b01,2'b00};
  localparam logic [19:0] C_WB_HU     = {6'b0,1'b0,1'b1,1'b1,1'b0, 2'b00,2'b00,2'b00,2'b10,2'b00};
  localparam logic [19:0] C_R_EXEC    = {9'b0,1'b1, 2'b00,2'b10,2'b00,2'b00,2'b00};
  localparam logic [19:0] C_R_WB      = {6'b0,1'b1,1'b0,1'b1,1'b0, 10'b0};
  localparam logic [19:0] C_BRANCH    = {1'b0,1'b1,7'b0,1'b1, 2'b00,2'b01,2'b01,2'b00,2'b00};
  localparam logic [19:0] C_ADDI_EX   = {9'b0,1'b1, 2'b10,2'b00,2'b00,2'b00,2'b00};
  localparam logic [19:0] C_ADDI_WB   = {8'b0,1'b1,1'b0, 10'b0};
  localparam logic [19:0] C_JUMP      = {1'b1,9'b0, 2'b00,2'b00,2'b10,2'b00,2'b00};
  localparam logic [19:0] F_ILL       = 20'h00002;
  localparam logic [19:0] F_TO        = 20'h00001;

  localparam logic [3:0] S_INIT = 4'd0, S_FETCH = 4'd1, S_DEC = 4'd2, S_MA = 4'd3,
                         S_MRD = 4'd4, S_MWB = 4'd5, S_MWR = 4'd6, S_REX = 4'd7,
                         S_RWB = 4'd8, S_BR = 4'd9, S_AEX = 4'd10, S_AWB = 4'd11,
                         S_JMP = 4'd12;

  localparam logic [5:0] O_R = 6'b000000, O_LW = 6'b100011, O_LH = 6'b100001,
                         O_LHU = 6'b100101, O_SW = 6'b101011, O_BEQ = 6'b000100,
                         O_ADDI = 6'b001000, O_J = 6'b000010, O_BAD = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [19:0] ctl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st,
                     input logic [19:0] ctl);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st; v.ctl = ctl;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  initial begin
    // R-type: 4 cycles, write only in R_WB
    add(O_R, 1'b1, S_FETCH, C_FETCH_RDY); add(O_R, 1'b1, S_DEC, C_DECODE);
    add(O_R, 1'b1, S_REX, C_R_EXEC);      add(O_R, 1'b1, S_RWB, C_R_WB);
    // lw with three stalled cycles; mem_ready arrives exactly at watchdog limit
    add(O_LW, 1'b1, S_FETCH, C_FETCH_RDY); add(O_LW, 1'b1, S_DEC, C_DECODE);
    add(O_LW, 1'b1, S_MA, C_MEM_ADDR);
    for (int k = 0; k < 3; k++) add(O_LW, 1'b0, S_MRD, C_MEM_RD);
    add(O_LW, 1'b1, S_MRD, C_MEM_RD);      add(O_LW, 1'b1, S_MWB, C_WB_W);
    // lh / lhu
    add(O_LH, 1'b1, S_FETCH, C_FETCH_RDY); add(O_LH, 1'b1, S_DEC, C_DECODE);
    add(O_LH, 1'b1, S_MA, C_MEM_ADDR);     add(O_LH, 1'b1, S_MRD, C_MEM_RD);
    add(O_LH, 1'b1, S_MWB, C_WB_H);
    add(O_LHU, 1'b1, S_FETCH, C_FETCH_RDY); add(O_LHU, 1'b1, S_DEC, C_DECODE);
    add(O_LHU, 1'b1, S_MA, C_MEM_ADDR);     add(O_LHU, 1'b1, S_MRD, C_MEM_RD);
    add(O_LHU, 1'b1, S_MWB, C_WB_HU);
    // sw with two stalled cycles
    add(O_SW, 1'b1, S_FETCH, C_FETCH_RDY); add(O_SW, 1'b1, S_DEC, C_DECODE);
    add(O_SW, 1'b1, S_MA, C_MEM_ADDR);
    add(O_SW, 1'b0, S_MWR, C_MEM_WR);      add(O_SW, 1'b0, S_MWR, C_MEM_WR);
    add(O_SW, 1'b1, S_MWR, C_MEM_WR);
    // beq, j, addi
    add(O_BEQ, 1'b1, S_FETCH, C_FETCH_RDY); add(O_BEQ, 1'b1, S_DEC, C_DECODE);
    add(O_BEQ, 1'b1, S_BR, C_BRANCH);
    add(O_J, 1'b1, S_FETCH, C_FETCH_RDY);   add(O_J, 1'b1, S_DEC, C_DECODE);
    add(O_J, 1'b1, S_JMP, C_JUMP);
    add(O_ADDI, 1'b1, S_FETCH, C_FETCH_RDY); add(O_ADDI, 1'b1, S_DEC, C_DECODE);
    add(O_ADDI, 1'b1, S_AEX, C_ADDI_EX);     add(O_ADDI, 1'b1, S_AWB, C_ADDI_WB);
    // illegal opcode: one-cycle pulse back in FETCH, gone by next DECODE
    add(O_BAD, 1'b1, S_FETCH, C_FETCH_RDY); add(O_BAD, 1'b1, S_DEC, C_DECODE);
    add(O_R, 1'b1, S_FETCH, C_FETCH_RDY | F_ILL); add(O_R, 1'b1, S_DEC, C_DECODE);
    add(O_R, 1'b1, S_REX, C_R_EXEC);        add(O_R, 1'b1, S_RWB, C_R_WB);
    // MEM_RD watchdog expiry: abort to FETCH, no MEM_WB
    add(O_LW, 1'b1, S_FETCH, C_FETCH_RDY); add(O_LW, 1'b1, S_DEC, C_DECODE);
    add(O_LW, 1'b1, S_MA, C_MEM_ADDR);
    for (int k = 0; k < 4; k++) add(O_LW, 1'b0, S_MRD, C_MEM_RD);
    add(O_J, 1'b1, S_FETCH, C_FETCH_RDY | F_TO); add(O_J, 1'b1, S_DEC, C_DECODE);
    add(O_J, 1'b1, S_JMP, C_JUMP);
    // FETCH watchdog expiry: fetch retries in place
    for (int k = 0; k < 4; k++) add(O_R, 1'b0, S_FETCH, C_FETCH_WT);
    add(O_R, 1'b1, S_FETCH, C_FETCH_RDY | F_TO); add(O_R, 1'b1, S_DEC, C_DECODE);
    add(O_R, 1'b1, S_REX, C_R_EXEC);        add(O_R, 1'b1, S_RWB, C_R_WB);
    // sw parked in MEM_WR for the reset-abort sequence below
    add(O_SW, 1'b1, S_FETCH, C_FETCH_RDY); add(O_SW, 1'b1, S_DEC, C_DECODE);
    add(O_SW, 1'b1, S_MA, C_MEM_ADDR);     add(O_SW, 1'b0, S_MWR, C_MEM_WR);

    rst_n = 1'b0;
    opcode = 6'd0;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(obs), 32'(C_ZERO));
    check("reset_state", 32'(state), 32'(S_INIT));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("init_state", 32'(state), 32'(S_INIT));
    check("init_outputs", 32'(obs), 32'(C_ZERO));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      opcode = vecs[i].op;
      mem_ready = vecs[i].mr;
      @(negedge clk);
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d_ctl", i), 32'(obs), 32'(vecs[i].ctl));
    end

    // asynchronous reset in the middle of a stalled store
    #2 rst_n = 1'b0;
    #1;
    check("midwr_reset_mem_write", 32'(mem_write), 32'd0);
    check("midwr_reset_outputs", 32'(obs), 32'(C_ZERO));
    check("midwr_reset_state", 32'(state), 32'(S_INIT));
    @(posedge clk); #1 rst_n = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check("post_reset_init", 32'(state), 32'(S_INIT));
    @(posedge clk); #1;
    @(negedge clk);
    check("post_reset_fetch", 32'(state), 32'(S_FETCH));
    check("post_reset_fetch_ctl", 32'(obs), 32'(C_FETCH_RDY));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
